// File: rtl/median_pkg.sv
// Shared definitions for the running-median filter: cell select encodings,
// window-length clamping and the age-field width helper.
package median_pkg;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_NEW   = 2'b01,
    SEL_LEFT  = 2'b10,
    SEL_RIGHT = 2'b11
  } sel_e;

  function automatic int age_width(input int win_max);
    return (win_max < 2) ? 1 : $clog2(win_max);
  endfunction

  // Legal window lengths are odd and within [3, win_max].
  function automatic int clamp_len(input int req, input int win_max);
    if (req < 3)       return 3;
    if (req > win_max) return win_max;
    if (req % 2 == 0)  return req - 1;
    return req;
  endfunction

endpackage

// File: rtl/median_cell_sel.sv
// Per-cell source select for the sorted window: decides whether a cell holds,
// loads the new sample, or shifts in a neighbour around the removal slot.
module median_cell_sel
  import median_pkg::*;
(
  input  logic       t_self,
  input  logic       t_left,
  input  logic       t_right,
  input  logic       above,
  input  logic       at_rem,
  input  logic       has_left,
  input  logic       has_right,
  input  logic       active,
  output logic [1:0] sel
);

  always_comb begin
    sel = SEL_HOLD;
    if (active) begin
      if (at_rem) begin
        // The vacated slot refills from whichever side the new sample displaces.
        if (has_right && !t_right)     sel = SEL_RIGHT;
        else if (has_left && t_left)   sel = SEL_LEFT;
        else                           sel = SEL_NEW;
      end else if (above) begin
        if (has_right && !t_right)     sel = SEL_RIGHT;
        else if (!t_self)              sel = SEL_NEW;
      end else begin
        if (has_left && t_left)        sel = SEL_LEFT;
        else if (t_self)               sel = SEL_NEW;
      end
    end
  end

endmodule

// File: rtl/median_window_filter.sv
// Running-median filter: sorted, age-tagged cell array updated with one
// insert/remove per accepted sample; median registered from the next state.
module median_window_filter
  import median_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int WIN_MAX = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [$clog2(WIN_MAX+1)-1:0] win_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data
);

  localparam int LEN_W = $clog2(WIN_MAX + 1);
  localparam int AGE_W = age_width(WIN_MAX);
  localparam int IDX_W = $clog2(WIN_MAX);

  logic [WIDTH-1:0]   val_q [WIN_MAX];
  logic [AGE_W-1:0]   age_q [WIN_MAX];
  logic [WIN_MAX-1:0] vld_q;
  logic [WIDTH-1:0]   val_n [WIN_MAX];
  logic [AGE_W-1:0]   age_n [WIN_MAX];
  logic [WIN_MAX-1:0] vld_n;

  logic [LEN_W-1:0]   cnt_q, cnt_n, len_q, mid;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;

  logic [WIN_MAX-1:0] t, t_l, t_r;
  logic [IDX_W-1:0]   rem_idx;
  logic               full, accept;
  logic [2*WIN_MAX-1:0] sel_flat;

  assign in_ready  = rst_n && !flush && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign full      = (cnt_q == len_q);
  assign mid       = (len_q - 1'b1) >> 1;
  assign cnt_n     = full ? cnt_q : cnt_q + 1'b1;

  // Invalid cells compare as +infinity so empty space sits above all data.
  always_comb begin
    for (int i = 0; i < WIN_MAX; i++)
      t[i] = (in_data < val_q[i]) || !vld_q[i];
  end

  assign t_l = {t[WIN_MAX-2:0], 1'b0};
  assign t_r = {1'b1, t[WIN_MAX-1:1]};

  // While filling, the first empty cell is the slot; once full, the oldest.
  always_comb begin
    rem_idx = cnt_q[IDX_W-1:0];
    if (full) begin
      rem_idx = '0;
      for (int i = 0; i < WIN_MAX; i++)
        if (vld_q[i] && (int'(age_q[i]) == int'(len_q) - 1))
          rem_idx = IDX_W'(i);
    end
  end

  for (genvar i = 0; i < WIN_MAX; i++) begin : g_cell
    median_cell_sel u_sel (
      .t_self   (t[i]),
      .t_left   (t_l[i]),
      .t_right  (t_r[i]),
      .above    (rem_idx < IDX_W'(i)),
      .at_rem   (rem_idx == IDX_W'(i)),
      .has_left (i > 0),
      .has_right(LEN_W'(i + 1) < len_q),
      .active   (LEN_W'(i) < len_q),
      .sel      (sel_flat[2*i +: 2])
    );
  end

  always_comb begin
    for (int i = 0; i < WIN_MAX; i++) begin
      val_n[i] = val_q[i];
      age_n[i] = vld_q[i] ? age_q[i] + 1'b1 : '0;
      vld_n[i] = vld_q[i];
      case (sel_flat[2*i +: 2])
        SEL_NEW: begin
          val_n[i] = in_data;
          age_n[i] = '0;
          vld_n[i] = 1'b1;
        end
        SEL_LEFT: begin
          val_n[i] = val_q[(i > 0) ? i - 1 : 0];
          age_n[i] = age_q[(i > 0) ? i - 1 : 0] + 1'b1;
          vld_n[i] = vld_q[(i > 0) ? i - 1 : 0];
        end
        SEL_RIGHT: begin
          val_n[i] = val_q[(i < WIN_MAX - 1) ? i + 1 : WIN_MAX - 1];
          age_n[i] = age_q[(i < WIN_MAX - 1) ? i + 1 : WIN_MAX - 1] + 1'b1;
          vld_n[i] = vld_q[(i < WIN_MAX - 1) ? i + 1 : WIN_MAX - 1];
        end
        default: ;
      endcase
      if (LEN_W'(i) >= len_q) begin
        age_n[i] = '0;
        vld_n[i] = 1'b0;
      end
    end
  end

  // Cell array, window bookkeeping and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_MAX; i++) begin
        val_q[i] <= '0;
        age_q[i] <= '0;
      end
      vld_q       <= '0;
      cnt_q       <= '0;
      len_q       <= LEN_W'(WIN_MAX);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (flush) begin
      for (int i = 0; i < WIN_MAX; i++)
        age_q[i] <= '0;
      vld_q       <= '0;
      cnt_q       <= '0;
      len_q       <= LEN_W'(clamp_len(int'(win_len), WIN_MAX));
      out_valid_q <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < WIN_MAX; i++) begin
        val_q[i] <= val_n[i];
        age_q[i] <= age_n[i];
      end
      vld_q       <= vld_n;
      cnt_q       <= cnt_n;
      out_valid_q <= (cnt_n == len_q);
      out_data_q  <= val_n[mid];
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_median_window_filter.sv
// Self-checking bench for median_window_filter: directed vector table, corner
// sequences and randomized traffic against a sliding-window sort model.
module tb_median_window_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] win_len = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  median_window_filter #(.WIDTH(8), .WIN_MAX(9)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .win_len  (win_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  int checks = 0;
  int errors = 0;

  int q[$];
  int mlen = 9;
  bit m_ov = 1'b0;
  int m_od = 0;

  typedef struct {
    int wl;
    int n;
    int d[10];
    int exp_last;
    int exp_nv;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_clamp(input int v);
    if (v < 3) return 3;
    if (v > 9) return 9;
    return (v % 2 == 1) ? v : v - 1;
  endfunction

  function automatic int model_median();
    int s[$];
    s = q;
    s.sort();
    return s[(s.size() - 1) / 2];
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit v, input int d, input bit ordy, input bit fl, input int wl);
    bit exp_rdy;
    in_valid  = v;
    in_data   = d[7:0];
    out_ready = ordy;
    flush     = fl;
    win_len   = wl[3:0];
    #1;
    exp_rdy = !fl && (!m_ov || ordy);
    chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
      mlen = model_clamp(wl);
      m_ov = 1'b0;
    end else if (v && exp_rdy) begin
      q.push_back(d & 255);
      if (q.size() > mlen) void'(q.pop_front());
      m_ov = (q.size() == mlen);
      if (m_ov) m_od = model_median();
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    chk("out_valid", out_valid, m_ov);
    if (m_ov) chk("out_data", out_data, m_od);
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    q.delete();
    mlen = 9;
    m_ov = 1'b0;
    m_od = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst in_ready", in_ready, 1);
    @(negedge clk);
  endtask

  initial begin
    int nv;
    tbl[0] = '{wl: 3,  n: 5,  d: '{5, 1, 9, 3, 7, 0, 0, 0, 0, 0},     exp_last: 7,  exp_nv: 3};
    tbl[1] = '{wl: 3,  n: 5,  d: '{4, 4, 4, 2, 2, 0, 0, 0, 0, 0},     exp_last: 2,  exp_nv: 3};
    tbl[2] = '{wl: 4,  n: 3,  d: '{2, 8, 5, 0, 0, 0, 0, 0, 0, 0},     exp_last: 5,  exp_nv: 1};
    tbl[3] = '{wl: 15, n: 10, d: '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0},     exp_last: 5,  exp_nv: 2};
    tbl[4] = '{wl: 1,  n: 3,  d: '{7, 3, 5, 0, 0, 0, 0, 0, 0, 0},     exp_last: 5,  exp_nv: 1};
    tbl[5] = '{wl: 5,  n: 6,  d: '{10, 20, 30, 40, 50, 5, 0, 0, 0, 0}, exp_last: 30, exp_nv: 2};
    tbl[6] = '{wl: 7,  n: 7,  d: '{9, 9, 1, 1, 5, 5, 3, 0, 0, 0},     exp_last: 5,  exp_nv: 1};

    @(negedge clk);
    do_reset();

    for (int r = 0; r < 7; r++) begin
      cycle(0, 0, 1, 1, tbl[r].wl);
      nv = 0;
      for (int j = 0; j < tbl[r].n; j++) begin
        cycle(1, tbl[r].d[j], 1, 0, 0);
        if (out_valid) nv++;
      end
      chk($sformatf("row%0d last median", r), out_data, tbl[r].exp_last);
      chk($sformatf("row%0d valid count", r), nv, tbl[r].exp_nv);
    end

    // Backpressure holds the first median and refuses new samples.
    cycle(0, 0, 1, 1, 3);
    cycle(1, 5, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(1, 9, 1, 0, 0);
    chk("bp first median", out_data, 5);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 3, 0, 0, 0);
      chk("bp held data", out_data, 5);
      chk("bp held valid", out_valid, 1);
    end
    cycle(1, 3, 1, 0, 0);
    chk("bp resumed median", out_data, 3);
    cycle(1, 7, 1, 0, 0);
    chk("bp next median", out_data, 7);

    // Flush alongside a valid sample drops the sample.
    cycle(0, 0, 1, 1, 5);
    for (int k = 0; k < 5; k++) cycle(1, 10 * (k + 1), 1, 0, 0);
    chk("pre-flush median", out_data, 30);
    cycle(1, 99, 1, 1, 3);
    chk("flush drops valid", out_valid, 0);
    cycle(1, 8, 1, 0, 0);
    cycle(1, 2, 1, 0, 0);
    cycle(1, 6, 1, 0, 0);
    chk("after flush median", out_data, 6);

    // Asynchronous reset mid-stream discards the window and restores len 9.
    cycle(0, 0, 1, 1, 5);
    for (int k = 0; k < 5; k++) cycle(1, 10 * (k + 1), 1, 0, 0);
    do_reset();
    cycle(1, 8, 1, 0, 0);
    cycle(1, 2, 1, 0, 0);
    cycle(1, 6, 1, 0, 0);
    chk("post-rst no median", out_valid, 0);
    cycle(0, 0, 1, 1, 3);
    cycle(1, 8, 1, 0, 0);
    cycle(1, 2, 1, 0, 0);
    cycle(1, 6, 1, 0, 0);
    chk("post-rst median", out_data, 6);

    // Random traffic with occasional flushes and backpressure.
    for (int k = 0; k < 600; k++) begin
      bit fl, v, ordy;
      int d, wl;
      fl   = ($urandom_range(0, 59) == 0);
      wl   = $urandom_range(0, 15);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      d    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(0, 7);
      cycle(v, d, ordy, fl, wl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
